// File: rtl/mmio_store_capture.sv
// ---------------------------------------------------------------------------
// mmio_store_capture
//
// Purpose:
//   Snoops the core's data-memory store stream. Stores that land inside a
//   memory-mapped I/O window are queued in a small FIFO. A host drains the
//   FIFO through a valid/ready port. Sticky FP exception flags, a saturating
//   exception-event counter and an interrupt summary are kept alongside.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   MemWriteM             store strobe (one store per cycle when high)
//   DataAdrM, WriteDataM  store byte address and data
//   Exception, Underflow, Overflow   FP status indications from the core
//   out_valid/out_ready   FIFO head handshake
//   out_addr, out_data    FIFO head entry (registered)
//   level                 FIFO occupancy
//   drop_cnt              saturating count of stores lost while full
//   flags_clr             clears the sticky flags and exc_cnt
//   exc_sticky, uf_sticky, of_sticky   sticky FP flags
//   exc_cnt               saturating count of Exception rising edges
//   irq                   interrupt summary
// ---------------------------------------------------------------------------
module mmio_store_capture #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
    parameter logic [31:0] MMIO_MASK  = 32'hFFFF_F000,
    parameter int          IRQ_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWriteM,
    input  logic [31:0]                  DataAdrM,
    input  logic [31:0]                  WriteDataM,
    input  logic                         Exception,
    input  logic                         Underflow,
    input  logic                         Overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_addr,
    output logic [31:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  drop_cnt,
    input  logic                         flags_clr,
    output logic                         exc_sticky,
    output logic                         uf_sticky,
    output logic                         of_sticky,
    output logic [7:0]                   exc_cnt,
    output logic                         irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(IRQ_THRESH);

    // Entry storage; contents are don't-care after reset, so no reset here.
    logic [31:0] addr_mem_q [DEPTH];
    logic [31:0] data_mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   head_addr_q, head_addr_d;
    logic [31:0]   head_data_q, head_data_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          exc_sticky_q, exc_sticky_d;
    logic          uf_sticky_q, uf_sticky_d;
    logic          of_sticky_q, of_sticky_d;
    logic          exc_prev_q;
    logic [7:0]    exc_cnt_q, exc_cnt_d;

    logic hit;
    logic push;
    logic pop;
    logic full;
    logic push_acc;
    logic drop;
    logic exc_rise;

    assign hit      = (DataAdrM & MMIO_MASK) == MMIO_BASE;
    assign push     = MemWriteM & hit;
    assign pop      = (level_q != '0) & out_ready;
    assign full     = (level_q == DEPTH_L);
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign push_acc = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign exc_rise = Exception & ~exc_prev_q;

    always_comb begin
        rd_ptr_d = pop      ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;

        level_d = level_q;
        case ({push_acc, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The head register is loaded with the entry that will sit at the
        // head next cycle. When that entry is being written right now it is
        // not yet in storage, so take it straight from the bus.
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        if (level_d != '0) begin
            if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
                head_addr_d = DataAdrM;
                head_data_d = WriteDataM;
            end else begin
                head_addr_d = addr_mem_q[rd_ptr_d];
                head_data_d = data_mem_q[rd_ptr_d];
            end
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        // A new event in the clear cycle survives the clear.
        exc_sticky_d = Exception | (exc_sticky_q & ~flags_clr);
        uf_sticky_d  = Underflow | (uf_sticky_q  & ~flags_clr);
        of_sticky_d  = Overflow  | (of_sticky_q  & ~flags_clr);

        exc_cnt_d = exc_cnt_q;
        if (flags_clr) begin
            exc_cnt_d = exc_rise ? 8'd1 : 8'd0;
        end else if (exc_rise && (exc_cnt_q != 8'hFF)) begin
            exc_cnt_d = exc_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_mem_q[wr_ptr_q] <= DataAdrM;
            data_mem_q[wr_ptr_q] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            head_addr_q  <= '0;
            head_data_q  <= '0;
            drop_cnt_q   <= '0;
            exc_sticky_q <= 1'b0;
            uf_sticky_q  <= 1'b0;
            of_sticky_q  <= 1'b0;
            exc_prev_q   <= 1'b0;
            exc_cnt_q    <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            head_addr_q  <= head_addr_d;
            head_data_q  <= head_data_d;
            drop_cnt_q   <= drop_cnt_d;
            exc_sticky_q <= exc_sticky_d;
            uf_sticky_q  <= uf_sticky_d;
            of_sticky_q  <= of_sticky_d;
            exc_prev_q   <= Exception;
            exc_cnt_q    <= exc_cnt_d;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_addr   = head_addr_q;
    assign out_data   = head_data_q;
    assign level      = level_q;
    assign drop_cnt   = drop_cnt_q;
    assign exc_sticky = exc_sticky_q;
    assign uf_sticky  = uf_sticky_q;
    assign of_sticky  = of_sticky_q;
    assign exc_cnt    = exc_cnt_q;
    assign irq        = (level_q >= THRESH_L) | exc_sticky_q | of_sticky_q;

endmodule

// File: tb/tb_mmio_store_capture.sv
// ---------------------------------------------------------------------------
// tb_mmio_store_capture
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model tracks what the block should hold; every step compares all outputs.
// ---------------------------------------------------------------------------
module tb_mmio_store_capture;

    localparam int          DEPTH      = 8;
    localparam logic [31:0] MMIO_BASE  = 32'h0000_1000;
    localparam logic [31:0] MMIO_MASK  = 32'hFFFF_F000;
    localparam int          IRQ_THRESH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic        Exception;
    logic        Underflow;
    logic        Overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  level;
    logic [15:0] drop_cnt;
    logic        flags_clr;
    logic        exc_sticky;
    logic        uf_sticky;
    logic        of_sticky;
    logic [7:0]  exc_cnt;
    logic        irq;

    mmio_store_capture #(
        .DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE), .MMIO_MASK(MMIO_MASK), .IRQ_THRESH(IRQ_THRESH)
    ) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
        .Exception(Exception), .Underflow(Underflow), .Overflow(Overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .level(level), .drop_cnt(drop_cnt), .flags_clr(flags_clr),
        .exc_sticky(exc_sticky), .uf_sticky(uf_sticky), .of_sticky(of_sticky),
        .exc_cnt(exc_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    // Reference model state
    logic [31:0] mq_addr[$];
    logic [31:0] mq_data[$];
    int          m_drop;
    bit          m_exc, m_uf, m_of, m_prev;
    int          m_cnt;
    logic [31:0] m_haddr, m_hdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model update from the inputs the DUT saw at this edge.
    task automatic model_update();
        bit hit, pop_m;
        if (reset) begin
            mq_addr.delete(); mq_data.delete();
            m_drop = 0; m_exc = 0; m_uf = 0; m_of = 0; m_prev = 0; m_cnt = 0;
            m_haddr = 0; m_hdata = 0;
            return;
        end
        hit   = MemWriteM && ((DataAdrM & MMIO_MASK) == MMIO_BASE);
        pop_m = (mq_addr.size() != 0) && out_ready;
        if (pop_m) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
        end
        if (hit) begin
            if (mq_addr.size() < DEPTH) begin
                mq_addr.push_back(DataAdrM);
                mq_data.push_back(WriteDataM);
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        if (mq_addr.size() != 0) begin
            m_haddr = mq_addr[0];
            m_hdata = mq_data[0];
        end
        if (flags_clr) begin
            m_cnt = 0; m_exc = 0; m_uf = 0; m_of = 0;
        end
        if (Exception && !m_prev && m_cnt < 255) m_cnt++;
        if (Exception) m_exc = 1;
        if (Underflow) m_uf = 1;
        if (Overflow)  m_of = 1;
        m_prev = Exception;
    endtask

    task automatic check_all();
        int sz;
        sz = mq_addr.size();
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("level", 32'(level), 32'(sz));
        chk("out_addr", out_addr, m_haddr);
        chk("out_data", out_data, m_hdata);
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("exc_sticky", 32'(exc_sticky), 32'(m_exc));
        chk("uf_sticky", 32'(uf_sticky), 32'(m_uf));
        chk("of_sticky", 32'(of_sticky), 32'(m_of));
        chk("exc_cnt", 32'(exc_cnt), 32'(m_cnt));
        chk("irq", 32'(irq), 32'((sz >= IRQ_THRESH) || m_exc || m_of));
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic ex, input logic u, input logic o,
                        input logic c, input logic r);
        reset = r; MemWriteM = we; DataAdrM = a; WriteDataM = d; out_ready = rdy;
        Exception = ex; Underflow = u; Overflow = o; flags_clr = c;
        @(posedge clk);
        model_update();
        #1;
        step_no++;
        $display("step %0d rst=%b we=%b a=%h d=%h rdy=%b ex/uf/of/clr=%b%b%b%b -> v=%b lvl=%0d head=%h drop=%0d cnt=%0d irq=%b",
                 step_no, r, we, a, d, rdy, ex, u, o, c, out_valid, level, out_data, drop_cnt, exc_cnt, irq);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        step(1'b1, a, d, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flags(input logic ex, input logic u, input logic o, input logic c);
        step(1'b0, 32'h0, 32'h0, 1'b0, ex, u, o, c, 1'b0);
    endtask

    initial begin
        logic [31:0] last;
        int n;
        int rcv;
        int pushed;

        // Reset state
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // Single hit, then a miss
        store(32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_addr", out_addr, 32'h0000_1004);
        chk("single_data", out_data, 32'hDEAD_BEEF);
        store(32'h0000_2000, 32'h1234_5678, 1'b0);
        chk("miss_level", 32'(level), 32'd1);
        idle(1'b1);
        chk("single_drained", 32'(out_valid), 32'd0);

        // Fill and drop
        for (int i = 0; i < 10; i++) store(32'h1000 + 32'(4 * i), 32'(i), 1'b0);
        chk("fill_level", 32'(level), 32'd8);
        chk("fill_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", out_data, 32'(i));
            idle(1'b1);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("hold_data", out_data, 32'd7);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) store(32'h1100 + 32'(4 * i), 32'h50 + 32'(i), 1'b0);
        store(32'h0000_1FFC, 32'hAA, 1'b1);
        chk("fullsim_level", 32'(level), 32'd8);
        chk("fullsim_drop", 32'(drop_cnt), 32'd2);
        n = 0;
        last = 32'h0;
        while (out_valid && n < 20) begin
            last = out_data;
            idle(1'b1);
            n++;
        end
        chk("fullsim_count", 32'(n), 32'd8);
        chk("fullsim_last", last, 32'hAA);

        // Pointer wraparound: bursts of 3 pushes then 3 pops
        rcv = 0;
        pushed = 0;
        for (int c = 0; c < 100 && rcv < 20; c++) begin
            logic we_w, rdy_w;
            we_w  = ((c % 6) < 3) && (pushed < 20);
            rdy_w = ((c % 6) >= 3);
            if (out_valid && rdy_w) begin
                chk("wrap_order", out_data, 32'd100 + 32'(rcv));
                rcv++;
            end
            store(we_w ? 32'h1000 + 32'(4 * pushed) : 32'h3000, 32'd100 + 32'(pushed), rdy_w);
            if (we_w) pushed++;
        end
        chk("wrap_received", 32'(rcv), 32'd20);

        // Flags and exception counter
        flags(1'b0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) flags(1'b1, 1'b0, 1'b0, 1'b0);
            flags(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("exc_cnt_two", 32'(exc_cnt), 32'd2);
        chk("exc_sticky_set", 32'(exc_sticky), 32'd1);
        chk("exc_irq", 32'(irq), 32'd1);
        flags(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_rise_sticky", 32'(exc_sticky), 32'd1);
        chk("clr_rise_cnt", 32'(exc_cnt), 32'd1);
        flags(1'b0, 1'b1, 1'b0, 1'b0);
        flags(1'b0, 1'b0, 1'b1, 1'b0);
        chk("of_sticky_set", 32'(of_sticky), 32'd1);
        flags(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_flags", 32'({exc_sticky, uf_sticky, of_sticky}), 32'd0);
        chk("clr_cnt", 32'(exc_cnt), 32'd0);

        // Threshold then reset
        for (int i = 0; i < 3; i++) store(32'h1000 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
        chk("thresh_below", 32'(irq), 32'd0);
        store(32'h100C, 32'hC3, 1'b0);
        chk("thresh_at", 32'(irq), 32'd1);
        step(1'b1, 32'h1010, 32'hC4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) != 0) ? {20'h00001, 12'($urandom)} : $urandom;
            step($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_store_capture.md
Name: mmio_store_capture

Overview:
- Downstream consumer of the RV32IF system top's data-memory bus and FP status outputs.
- Snoops the core's store stream (write-enable, address, write data).
- Stores that hit a memory-mapped I/O window are queued in a FIFO. A host or test harness drains the FIFO through a valid/ready port.
- Sticky FP exception flags and an exception-event counter are kept alongside, with an interrupt summary output.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- MMIO_BASE, 32'h0000_1000, window base address.
- MMIO_MASK, 32'hFFFF_F000, address match mask; hit when (DataAdrM & MMIO_MASK) == MMIO_BASE.
- IRQ_THRESH, 4, FIFO level at or above which irq asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWriteM  in  1  core store strobe, one store per cycle when high.
- DataAdrM  in  32  store byte address.
- WriteDataM  in  32  store data.
- Exception  in  1  FP exception indication from core.
- Underflow  in  1  FP underflow indication.
- Overflow  in  1  FP overflow indication.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  32  head entry address.
- out_data  out  32  head entry data.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- drop_cnt  out  16  count of stores lost because the FIFO was full; saturating.
- flags_clr  in  1  clears sticky flags and exc_cnt.
- exc_sticky  out  1  sticky Exception.
- uf_sticky  out  1  sticky Underflow.
- of_sticky  out  1  sticky Overflow.
- exc_cnt  out  8  rising edges of Exception; saturating at 255.
- irq  out  1  interrupt summary.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: level=0, out_valid=0, out_addr=0, out_data=0, drop_cnt=0, all sticky flags=0, exc_cnt=0, previous-Exception register=0, irq=0. FIFO contents are don't-care after reset.
- Reset mid-operation: queued entries are discarded; no pop is reported.
- push = MemWriteM & window hit.
- pop = out_valid & out_ready.
- Push latency: an entry pushed in cycle N appears at the head in cycle N+1 if the FIFO was empty. Head outputs come directly from storage registers, with no combinational path from the bus inputs.
- out_valid = (level != 0).
- When out_valid=0, out_addr and out_data hold their last value.
- Entry format: full 32-bit DataAdrM and 32-bit WriteDataM, captured in the push cycle.
- Ordering: strict FIFO; read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full (level==DEPTH) and push with no pop: the store is dropped and drop_cnt increments, saturating at 16'hFFFF.
- Full with push and pop in the same cycle: both happen, level stays DEPTH, nothing is dropped.
- Empty with push and pop in the same cycle: the pop is invalid (out_valid=0), so only the push happens.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Non-hit stores and MemWriteM=0 cycles are ignored.
- Sticky flags: set in the cycle after the input is seen high; cleared by flags_clr.
- Simultaneous set and flags_clr: set wins, so the flag reads 1 the next cycle.
- exc_cnt: increments when Exception=1 and the previous-cycle Exception=0; saturates at 255.
- flags_clr also zeroes exc_cnt. If a rising edge coincides with flags_clr, exc_cnt becomes 1.
- flags_clr does not affect the FIFO or drop_cnt.
- irq = (level >= IRQ_THRESH) | exc_sticky | of_sticky. It is combinational from registered state only.

Test Plan:
- Single hit: reset, then a store to 0x1004 with data 0xDEADBEEF, out_ready=0 → next cycle out_valid=1, out_addr=0x1004, out_data=0xDEADBEEF, level=1. Store to 0x2000 → no change.
- Fill and drop: 10 consecutive hit stores 0x1000+4i with data i, out_ready=0 → level=8, drop_cnt=2. Draining with out_ready=1 yields data 0..7 in order, then out_valid=0.
- Full simultaneous: with the FIFO full, push data 0xAA and pop in the same cycle → level stays 8, drop_cnt unchanged, 0xAA is the last entry drained.
- Pointer wraparound: 20 interleaved push/pop cycles with level oscillating between 0 and 3 → all 20 data values drain in order with no loss.
- Flags: pulse Exception high for 3 cycles, twice → exc_cnt=2, exc_sticky=1, irq=1. Assert flags_clr in the same cycle as a new rising edge → exc_sticky=1, exc_cnt=1.
- Threshold and reset: push 4 entries → irq=1 when level=4. Assert reset for one cycle → level=0, out_valid=0, irq=0, drop_cnt=0.
